// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_if
// Description : Request and instruction-memory write bundle for instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256
);
    localparam int c_count_w = $clog2(DEPTH + 1);

    logic                  start;
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_kind;
    logic [4:0]            req_rd;
    logic [4:0]            req_rs1;
    logic [4:0]            req_rs2;
    logic [12:0]           req_imm;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic [c_count_w-1:0]  count;
    logic                  full;
    logic                  err;
    logic [1:0]            err_code;

    modport master (
        output start, req_valid, req_kind, req_rd, req_rs1, req_rs2, req_imm,
        input  req_ready, imem_we, imem_addr, imem_wdata, count, full, err, err_code
    );

    modport slave (
        input  start, req_valid, req_kind, req_rd, req_rs1, req_rs2, req_imm,
        output req_ready, imem_we, imem_addr, imem_wdata, count, full, err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Encodes symbolic ADDI/BNE/LW requests into RV32I words and
//               writes them sequentially into instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    instr_encoder_if.slave   bus
);
    localparam int                  c_count_w  = $clog2(DEPTH + 1);
    localparam int                  c_last_i   = DEPTH - 1;
    localparam logic [c_count_w-1:0] c_depth   = DEPTH[c_count_w-1:0];
    localparam logic [c_count_w-1:0] c_last    = c_last_i[c_count_w-1:0];
    localparam logic [c_count_w:0]   c_depth_x = DEPTH[c_count_w:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [31:0]           r_wdata;
    logic [c_count_w-1:0]  r_count;
    logic [1:0]            r_err_code;

    logic                  w_fire;
    logic [1:0]            w_code;
    logic [31:0]           w_word;
    logic [c_count_w:0]    w_used;

    // The in-flight write is counted so the last free slot is never double-booked.
    assign w_used        = {1'b0, r_count} + {{c_count_w{1'b0}}, r_we};
    assign bus.req_ready = (r_state == RUN) && (w_used < c_depth_x);
    assign w_fire        = bus.req_valid && bus.req_ready && !bus.start;

    always_comb begin
        w_code = 2'b00;
        w_word = '0;
        case (bus.req_kind)
            2'b00: begin
                w_word = {bus.req_imm[11:0], bus.req_rs1, 3'b000, bus.req_rd, 7'b0010011};
                if (bus.req_imm[12] != bus.req_imm[11]) w_code = 2'b10;
            end
            2'b10: begin
                w_word = {bus.req_imm[11:0], bus.req_rs1, 3'b010, bus.req_rd, 7'b0000011};
                if (bus.req_imm[12] != bus.req_imm[11]) w_code = 2'b10;
            end
            2'b01: begin
                w_word = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1,
                          3'b001, bus.req_imm[4:1], bus.req_imm[11], 7'b1100011};
                if (bus.req_imm[0]) w_code = 2'b11;
            end
            default: w_code = 2'b01;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_ptr      <= BASE_ADDR;
            r_wdata    <= '0;
            r_count    <= '0;
            r_err_code <= 2'b00;
        end else if (bus.start) begin
            r_state    <= RUN;
            r_we       <= 1'b0;
            r_ptr      <= BASE_ADDR;
            r_count    <= '0;
            r_err_code <= 2'b00;
        end else begin
            r_we <= 1'b0;
            // Pointer and count retire with the write itself.
            if (r_we) begin
                r_ptr   <= r_ptr + ADDR_WIDTH'(4);
                r_count <= r_count + c_count_w'(1);
                if (r_state == RUN && r_count == c_last) r_state <= DONE;
            end
            if (w_fire) begin
                if (w_code == 2'b00) begin
                    r_we    <= 1'b1;
                    r_wdata <= w_word;
                end else begin
                    r_state    <= ERR;
                    r_err_code <= w_code;
                end
            end
        end
    end

    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_ptr;
    assign bus.imem_wdata = r_wdata;
    assign bus.count      = r_count;
    assign bus.full       = (r_count == c_depth);
    assign bus.err        = (r_state == ERR);
    assign bus.err_code   = r_err_code;
endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed scoreboard bench for instr_encoder (DEPTH 256 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_WIDTH(32), .DEPTH(256)) bus  ();
    instr_encoder_if #(.ADDR_WIDTH(32), .DEPTH(4))   bus4 ();

    instr_encoder #(.ADDR_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    instr_encoder #(.ADDR_WIDTH(32), .DEPTH(4), .BASE_ADDR(32'h0)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q[$];
    logic [63:0] q4[$];
    logic [63:0] exp_m;
    logic [63:0] exp_m4;
    logic [31:0] exp_ptr;
    logic [31:0] exp_ptr4;
    int          writes4 = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_ptr   = 32'h0;
    endtask

    // Present one request, wait for acceptance, and queue the expected write if legal.
    task automatic send(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [12:0] imm,
                        input logic [31:0] word, input logic legal);
        int n = 0;
        bus.req_kind  = k;
        bus.req_rd    = rd;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_imm   = imm;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        assert (bus.req_ready === 1'b1) else begin
            errors++;
            $error("FAIL ready_timeout: observed=%b expected=1", bus.req_ready);
        end
        if (legal) begin
            q.push_back({exp_ptr, word});
            exp_ptr = exp_ptr + 32'd4;
        end
        tick();
        bus.req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            checks++;
            exp_m = (q.size() != 0) ? q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            assert ({bus.imem_addr, bus.imem_wdata} === exp_m) else begin
                errors++;
                $error("FAIL write: observed=%h_%h expected=%h", bus.imem_addr, bus.imem_wdata, exp_m);
            end
        end
    end

    always @(negedge clk) begin
        if (bus4.imem_we === 1'b1) begin
            checks++;
            writes4++;
            exp_m4 = (q4.size() != 0) ? q4.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            assert ({bus4.imem_addr, bus4.imem_wdata} === exp_m4) else begin
                errors++;
                $error("FAIL write4: observed=%h_%h expected=%h", bus4.imem_addr, bus4.imem_wdata, exp_m4);
            end
        end
    end

    initial begin
        int  accepted = 0;
        logic seen_low = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0;  bus.req_valid = 1'b0; bus.req_kind = 2'b00;
        bus.req_rd = '0;   bus.req_rs1 = '0;     bus.req_rs2 = '0; bus.req_imm = '0;
        bus4.start = 1'b0; bus4.req_valid = 1'b0; bus4.req_kind = 2'b00;
        bus4.req_rd = '0;  bus4.req_rs1 = '0;     bus4.req_rs2 = '0; bus4.req_imm = '0;
        exp_ptr = 32'h0;
        exp_ptr4 = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_ready", {63'd0, bus.req_ready}, 64'd0);
        chk("rst_we",    {63'd0, bus.imem_we}, 64'd0);
        chk("rst_addr",  {32'd0, bus.imem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, bus.imem_wdata}, 64'd0);
        chk("rst_count", {55'd0, bus.count}, 64'd0);
        chk("rst_flags", {59'd0, bus.full, bus.err, bus.err_code}, 64'd0);
        tick();
        chk("idle_ready", {63'd0, bus.req_ready}, 64'd0);

        // Single ADDI
        do_start();
        chk("run_ready", {63'd0, bus.req_ready}, 64'd1);
        send(2'b00, 5'd1, 5'd0, 5'd0, 13'd5, 32'h0050_0093, 1'b1);
        chk("addi_we", {63'd0, bus.imem_we}, 64'd1);
        tick();
        chk("addi_count", {55'd0, bus.count}, 64'd1);
        chk("addi_ptr",   {32'd0, bus.imem_addr}, 64'd4);

        // Back-to-back LW/BNE plus immediate boundaries
        do_start();
        send(2'b10, 5'd2,  5'd1,  5'd0, 13'd8,       32'h0080_A103, 1'b1);
        send(2'b01, 5'd0,  5'd1,  5'd2, 13'h1FF8,    32'hFE20_9CE3, 1'b1);
        send(2'b00, 5'd31, 5'd31, 5'd0, 13'h1800,    32'h800F_8F93, 1'b1);
        send(2'b10, 5'd0,  5'd5,  5'd0, 13'h07FF,    32'h7FF2_A003, 1'b1);
        send(2'b01, 5'd0,  5'd3,  5'd4, 13'h1000,    32'h8041_9063, 1'b1);
        send(2'b01, 5'd0,  5'd0,  5'd0, 13'h0FFE,    32'h7E00_1FE3, 1'b1);
        tick();
        chk("b2b_count", {55'd0, bus.count}, 64'd6);
        chk("b2b_err",   {63'd0, bus.err}, 64'd0);

        // ADDI out of range
        do_start();
        send(2'b00, 5'd1, 5'd0, 5'd0, 13'h0800, 32'h0, 1'b0);
        chk("range_we",    {63'd0, bus.imem_we}, 64'd0);
        chk("range_err",   {63'd0, bus.err}, 64'd1);
        chk("range_code",  {62'd0, bus.err_code}, 64'd2);
        chk("range_ready", {63'd0, bus.req_ready}, 64'd0);
        do_start();
        chk("clr_err",   {63'd0, bus.err}, 64'd0);
        chk("clr_code",  {62'd0, bus.err_code}, 64'd0);
        chk("clr_count", {55'd0, bus.count}, 64'd0);
        chk("clr_addr",  {32'd0, bus.imem_addr}, 64'd0);

        // Odd BNE offset, then reserved kind
        send(2'b01, 5'd0, 5'd1, 5'd2, 13'd3, 32'h0, 1'b0);
        chk("odd_code", {62'd0, bus.err_code}, 64'd3);
        tick();
        chk("odd_sticky", {62'd0, bus.err_code}, 64'd3);
        do_start();
        send(2'b11, 5'd1, 5'd1, 5'd1, 13'd0, 32'h0, 1'b0);
        chk("rsv_code", {62'd0, bus.err_code}, 64'd1);
        chk("rsv_err",  {63'd0, bus.err}, 64'd1);

        // Reset during an in-flight write with a second request pending
        do_start();
        send(2'b00, 5'd4, 5'd4, 5'd0, 13'd1, 32'h0012_0213, 1'b1);
        bus.req_kind  = 2'b00;
        bus.req_imm   = 13'd2;
        bus.req_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 1'b0;
        chk("mid_rst_we",    {63'd0, bus.imem_we}, 64'd0);
        chk("mid_rst_addr",  {32'd0, bus.imem_addr}, 64'd0);
        chk("mid_rst_wdata", {32'd0, bus.imem_wdata}, 64'd0);
        chk("mid_rst_count", {55'd0, bus.count}, 64'd0);
        chk("mid_rst_ready", {63'd0, bus.req_ready}, 64'd0);

        // start wins over a same-cycle handshake
        do_start();
        bus.req_kind  = 2'b00;
        bus.req_imm   = 13'd7;
        bus.req_valid = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.req_valid = 1'b0;
        exp_ptr       = 32'h0;
        chk("start_pri_we", {63'd0, bus.imem_we}, 64'd0);
        tick();
        chk("start_pri_count", {55'd0, bus.count}, 64'd0);

        // DEPTH=4 instance saturates
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        bus4.req_valid = 1'b1;
        bus4.req_kind  = 2'b00;
        bus4.req_rd    = 5'd3;
        for (int i = 0; i < 8; i++) begin
            bus4.req_imm = 13'(i + 1);
            if (bus4.req_ready) begin
                q4.push_back({exp_ptr4, {12'(i + 1), 5'd0, 3'b000, 5'd3, 7'h13}});
                exp_ptr4 = exp_ptr4 + 32'd4;
                accepted++;
            end
            tick();
            if (accepted == 4 && !seen_low) begin
                seen_low = 1'b1;
                chk("d4_ready_low", {63'd0, bus4.req_ready}, 64'd0);
            end
        end
        bus4.req_valid = 1'b0;
        tick();
        chk("d4_accepted", 64'(accepted), 64'd4);
        chk("d4_writes",   64'(writes4), 64'd4);
        chk("d4_count",    {61'd0, bus4.count}, 64'd4);
        chk("d4_full",     {63'd0, bus4.full}, 64'd1);
        chk("d4_ready",    {63'd0, bus4.req_ready}, 64'd0);

        tick();
        chk("q_drained",  64'(q.size()), 64'd0);
        chk("q4_drained", 64'(q4.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
